// File: rtl/ps2_tetris_key_decoder_if.sv
// Byte stream from the PS/2 receiver into the key decoder, and the game command
// pulses plus held-key flags going out to the Tetris controller.
interface ps2_tetris_key_decoder_if;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       cmd_left;
  logic       cmd_right;
  logic       cmd_down;
  logic       cmd_rotate;
  logic       cmd_drop;
  logic       cmd_pause;
  logic [5:0] held;

  modport master (
    output ps2_key_data,
    output ps2_key_pressed,
    input  cmd_left,
    input  cmd_right,
    input  cmd_down,
    input  cmd_rotate,
    input  cmd_drop,
    input  cmd_pause,
    input  held
  );

  modport slave (
    input  ps2_key_data,
    input  ps2_key_pressed,
    output cmd_left,
    output cmd_right,
    output cmd_down,
    output cmd_rotate,
    output cmd_drop,
    output cmd_pause,
    output held
  );
endinterface

// File: rtl/ps2_tetris_key_decoder.sv
// Set-2 scan-code decoder for Tetris: tracks make/break/E0 prefixes, keeps held-key
// flags and produces one-cycle command pulses with internal auto-repeat on left/right/down.
module ps2_tetris_key_decoder #(
  parameter int unsigned REPEAT_DELAY = 32'd12500000,
  parameter int unsigned REPEAT_RATE  = 32'd5000000,
  parameter int unsigned CNT_W        = 32'd24
) (
  input  logic                    inclock,
  input  logic                    resetn,
  ps2_tetris_key_decoder_if.slave kbd
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_e;

  // Held/command bit order: {pause, drop, rotate, down, right, left}; the low
  // N_REP keys are the ones with an auto-repeat counter.
  localparam int N_REP = 3;

  localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Maps a completed sequence to a one-hot game key; extended and normal codes
  // live in separate tables so numpad 6B never aliases the arrow key.
  function automatic logic [5:0] key_decode(input logic ext, input logic [7:0] code);
    logic [5:0] k;
    k = 6'b000000;
    if (ext) begin
      case (code)
        8'h6B:   k = 6'b000001;
        8'h74:   k = 6'b000010;
        8'h72:   k = 6'b000100;
        8'h75:   k = 6'b001000;
        default: k = 6'b000000;
      endcase
    end else begin
      case (code)
        8'h29:   k = 6'b010000;
        8'h76:   k = 6'b100000;
        default: k = 6'b000000;
      endcase
    end
    return k;
  endfunction

  state_e                      state_q, state_d;
  logic                        seq_done_s;
  logic                        seq_ext_s;
  logic                        seq_brk_s;
  logic [5:0]                  key_hit_s;
  logic [5:0]                  make_s;
  logic [5:0]                  brk_s;
  logic [N_REP-1:0]            rep_pulse_s;
  logic [5:0]                  held_q, held_d;
  logic [5:0]                  cmd_q, cmd_d;
  logic [N_REP-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Prefix FSM state register.
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Prefix FSM next state and completed-sequence classification.
  always_comb begin
    state_d    = state_q;
    seq_done_s = 1'b0;
    seq_ext_s  = 1'b0;
    seq_brk_s  = 1'b0;
    if (kbd.ps2_key_pressed) begin
      case (state_q)
        IDLE: begin
          if (kbd.ps2_key_data == 8'hE0) begin
            state_d = EXT;
          end else if (kbd.ps2_key_data == 8'hF0) begin
            state_d = BRK;
          end else begin
            seq_done_s = 1'b1;
          end
        end
        EXT: begin
          if (kbd.ps2_key_data == 8'hF0) begin
            state_d = EXT_BRK;
          end else if (kbd.ps2_key_data == 8'hE0) begin
            state_d = EXT;
          end else begin
            seq_done_s = 1'b1;
            seq_ext_s  = 1'b1;
            state_d    = IDLE;
          end
        end
        BRK: begin
          seq_done_s = 1'b1;
          seq_brk_s  = 1'b1;
          state_d    = IDLE;
        end
        EXT_BRK: begin
          seq_done_s = 1'b1;
          seq_ext_s  = 1'b1;
          seq_brk_s  = 1'b1;
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Key events for the cycle: the final byte of a sequence, split into make/break.
  always_comb begin
    key_hit_s = 6'b000000;
    make_s    = 6'b000000;
    brk_s     = 6'b000000;
    if (seq_done_s) begin
      key_hit_s = key_decode(seq_ext_s, kbd.ps2_key_data);
    end else begin
      key_hit_s = 6'b000000;
    end
    if (seq_brk_s) begin
      brk_s = key_hit_s;
    end else begin
      make_s = key_hit_s;
    end
  end

  // Repeat counters: a fresh press arms the delay, a break disarms, a held key
  // counts down to 1 and then fires and re-arms with the rate. Typematic makes
  // of an already-held key leave the countdown running undisturbed.
  always_comb begin
    cnt_d       = cnt_q;
    rep_pulse_s = {N_REP{1'b0}};
    for (int i = 0; i < N_REP; i++) begin
      if (brk_s[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (make_s[i] && !held_q[i]) begin
        cnt_d[i] = DELAY_LD;
      end else if (held_q[i]) begin
        if (cnt_q[i] == CNT_ONE) begin
          cnt_d[i]       = RATE_LD;
          rep_pulse_s[i] = 1'b1;
        end else if (cnt_q[i] > CNT_ONE) begin
          cnt_d[i] = cnt_q[i] - CNT_ONE;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Held flags and command pulses for the next cycle.
  always_comb begin
    held_d = (held_q | make_s) & ~brk_s;
    cmd_d  = (make_s & ~held_q) | {3'b000, rep_pulse_s};
  end

  // Held flags, registered command pulses and repeat counters.
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      held_q <= 6'b000000;
      cmd_q  <= 6'b000000;
      cnt_q  <= {N_REP{CNT_ZERO}};
    end else begin
      held_q <= held_d;
      cmd_q  <= cmd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign kbd.cmd_left   = cmd_q[0];
  assign kbd.cmd_right  = cmd_q[1];
  assign kbd.cmd_down   = cmd_q[2];
  assign kbd.cmd_rotate = cmd_q[3];
  assign kbd.cmd_drop   = cmd_q[4];
  assign kbd.cmd_pause  = cmd_q[5];
  assign kbd.held       = held_q;

endmodule

// File: tb/tb_ps2_tetris_key_decoder.sv
// Bench for ps2_tetris_key_decoder: directed scenarios plus random byte streams,
// checked every cycle against a sequence-level model with closed-form repeat times.
module tb_ps2_tetris_key_decoder;
  localparam int RD = 20;
  localparam int RR = 8;
  localparam logic [7:0] KEY_CODE [6] = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h29, 8'h76};
  localparam logic       KEY_EXT  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [7:0] POOL [13] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h72, 8'h75, 8'h29,
                                       8'h76, 8'h12, 8'hE1, 8'h14, 8'hE0, 8'hF0};

  logic clk;
  logic resetn;
  ps2_tetris_key_decoder_if bus();

  ps2_tetris_key_decoder #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(24)) dut (
    .inclock (clk),
    .resetn  (resetn),
    .kbd     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       chk_en = 1'b0;
  logic [5:0] exp_cmd = 6'b0;
  logic [5:0] exp_held = 6'b0;
  logic [5:0] m_held = 6'b0;
  int         m_t0 [6];
  logic [7:0] seq [$];
  int         pulse_cyc [$];
  int         pulse_key [$];
  int         expq [$];

  // Per-cycle comparison against the model, and a log of every observed pulse.
  initial begin
    logic [5:0] got;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        got = {bus.cmd_pause, bus.cmd_drop, bus.cmd_rotate, bus.cmd_down, bus.cmd_right, bus.cmd_left};
        checks++;
        if (got !== exp_cmd || bus.held !== exp_held) begin
          errors++;
          $display("FAIL cycle_compare cyc=%0d cmd got %b exp %b held got %b exp %b",
                   cyc, got, exp_cmd, bus.held, exp_held);
        end
        for (int k = 0; k < 6; k++) begin
          if (got[k] === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_key.push_back(k);
          end
        end
      end
    end
  end

  // A byte ends a sequence unless it is an E0/F0 prefix arriving before any F0.
  task automatic parse_byte(input logic [7:0] b, output logic [5:0] mk, output logic [5:0] bk);
    logic has_f0;
    logic ext;
    mk = 6'b0;
    bk = 6'b0;
    has_f0 = 1'b0;
    for (int i = 0; i < seq.size(); i++) if (seq[i] == 8'hF0) has_f0 = 1'b1;
    seq.push_back(b);
    if (!has_f0 && (b == 8'hE0 || b == 8'hF0)) return;
    ext = (seq[0] == 8'hE0);
    seq.delete();
    for (int k = 0; k < 6; k++) begin
      if (KEY_CODE[k] == b && KEY_EXT[k] == ext) begin
        if (has_f0) bk[k] = 1'b1;
        else        mk[k] = 1'b1;
      end
    end
  endtask

  // Drive one cycle of input and derive the outputs expected on the next cycle.
  task automatic step(input logic stb, input logic [7:0] b);
    logic [5:0] mk, bk, pulse;
    int d;
    bus.ps2_key_pressed = stb;
    bus.ps2_key_data    = b;
    mk = 6'b0;
    bk = 6'b0;
    if (stb) parse_byte(b, mk, bk);
    pulse = 6'b0;
    for (int k = 0; k < 6; k++) begin
      if (mk[k] && !m_held[k]) begin
        pulse[k] = 1'b1;
        m_held[k] = 1'b1;
        m_t0[k] = cyc;
      end else if (bk[k]) begin
        m_held[k] = 1'b0;
      end else if (m_held[k] && k < 3) begin
        d = cyc + 1 - m_t0[k];
        if (d > RD && ((d - RD - 1) % RR) == 0) pulse[k] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_cmd  = pulse;
    exp_held = m_held;
    bus.ps2_key_pressed = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic check_val(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", name, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    bus.ps2_key_pressed = 1'b0;
    bus.ps2_key_data = 8'h00;
    seq.delete();
    m_held = 6'b0;
    exp_cmd = 6'b0;
    exp_held = 6'b0;
    #2;
    check_val("reset_held", bus.held, 6'b000000);
    check_val("reset_cmd", {bus.cmd_pause, bus.cmd_drop, bus.cmd_rotate,
                            bus.cmd_down, bus.cmd_right, bus.cmd_left}, 6'b000000);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    resetn = 1'b1;
  endtask

  // Compares pulse offsets of one key (logged since mark) against expq.
  task automatic check_list(input string name, input int key, input int refc, input int mark);
    int got [$];
    for (int i = 0; i < pulse_cyc.size(); i++)
      if (pulse_key[i] == key && pulse_cyc[i] >= mark) got.push_back(pulse_cyc[i] - refc);
    checks++;
    if (got.size() != expq.size()) begin
      errors++;
      $display("FAIL %s pulse_count got %0d exp %0d", name, got.size(), expq.size());
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        checks++;
        if (got[i] != expq[i]) begin
          errors++;
          $display("FAIL %s pulse %0d offset got %0d exp %0d", name, i, got[i], expq[i]);
        end
      end
    end
  endtask

  task automatic check_total(input string name, input int mark, input int exp_n);
    int n;
    n = 0;
    for (int i = 0; i < pulse_cyc.size(); i++) if (pulse_cyc[i] >= mark) n++;
    checks++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL %s total_pulses got %0d exp %0d", name, n, exp_n);
    end
  endtask

  initial begin
    int mark, r, r2;
    resetn = 1'b0;
    bus.ps2_key_pressed = 1'b0;
    bus.ps2_key_data = 8'h00;
    for (int k = 0; k < 6; k++) m_t0[k] = 0;
    #1;
    chk_en = 1'b1;
    do_reset(3);
    idle(2);
    check_val("post_reset_held", bus.held, 6'b000000);

    // Drop press and release.
    mark = cyc;
    r = cyc;
    send(8'h29);
    idle(1);
    check_val("t1_held_drop", bus.held, 6'b010000);
    send(8'hF0);
    send(8'h29);
    idle(2);
    check_val("t1_held_clear", bus.held, 6'b000000);
    expq = '{1};
    check_list("t1_drop", 4, r, mark);
    check_total("t1_only_drop", mark, 1);

    // Left auto-repeat schedule.
    mark = cyc;
    send(8'hE0);
    r = cyc;
    send(8'h6B);
    idle(49);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    idle(20);
    expq = '{1, 21, 29, 37, 45};
    check_list("t2_left", 0, r, mark);
    check_val("t2_held_clear", bus.held, 6'b000000);

    // Typematic rotate makes produce a single pulse.
    mark = cyc;
    send(8'hE0);
    r = cyc;
    send(8'h75);
    for (int i = 0; i < 2; i++) begin
      idle(3);
      send(8'hE0);
      send(8'h75);
    end
    idle(2);
    check_val("t3_held_rot", bus.held, 6'b001000);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    idle(2);
    check_val("t3_held_clear", bus.held, 6'b000000);
    expq = '{1};
    check_list("t3_rotate", 3, r, mark);

    // Numpad 6B and unmapped extended code are ignored.
    mark = cyc;
    send(8'h6B);
    send(8'hF0);
    send(8'h6B);
    idle(3);
    check_val("t4_held_numpad", bus.held, 6'b000000);
    send(8'hE0);
    send(8'h12);
    r = cyc;
    send(8'h76);
    idle(2);
    check_val("t4_held_pause", bus.held, 6'b100000);
    expq = {};
    check_list("t4_no_left", 0, r, mark);
    expq = '{1};
    check_list("t4_pause", 5, r, mark);
    send(8'hF0);
    send(8'h76);
    idle(2);

    // Left and right held together repeat on their own schedules.
    mark = cyc;
    send(8'hE0);
    r = cyc;
    send(8'h6B);
    send(8'hE0);
    r2 = cyc;
    send(8'h74);
    idle(37);
    check_val("t5_held_both", bus.held, 6'b000011);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    send(8'hE0);
    send(8'hF0);
    send(8'h74);
    idle(10);
    expq = '{1, 21, 29, 37};
    check_list("t5_left", 0, r, mark);
    check_list("t5_right", 1, r2, mark);

    // Reset in the middle of an extended sequence.
    mark = cyc;
    send(8'hE0);
    send(8'h6B);
    idle(2);
    check_val("t6_held_pre", bus.held, 6'b000001);
    send(8'hE0);
    do_reset(2);
    send(8'h6B);
    idle(3);
    check_val("t6_held_post", bus.held, 6'b000000);
    expq = '{1};
    check_list("t6_left", 0, mark + 1, mark);

    // Random byte streams with gaps and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 2) do_reset($urandom_range(1, 3));
      else if (r < 110) idle(1);
      else send(POOL[$urandom_range(0, 12)]);
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
